// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master sequencer: splits each bit into four timer-driven phases (A..D)
// and drives open-drain SCL/SDA enables. Define I2C_BIT_CTRL_STRETCH_EN for SCL stretching.
module i2c_bit_ctrl #(
   parameter int unsigned SIZE = 8
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic [SIZE-1:0] Ticks_cfg,
   input  logic [1:0]      Cmd,
   input  logic            Cmd_valid,
   output logic            Cmd_ready,
   input  logic            Tx_bit,
   output logic            Done,
   output logic            Rx_bit,
   output logic            Arb_lost,
   output logic            Busy,
   output logic            Scl_oe,
   output logic            Sda_oe,
   input  logic            Scl_i,
   input  logic            Sda_i,
   output logic [SIZE-1:0] Tmr_Ticks,
   output logic            Tmr_Start,
   output logic            Tmr_Stop,
   input  logic            Tmr_Out
);

   typedef enum logic [2:0] {StIdle, StPhA, StPhB, StPhC, StPhD, StWaitScl} state_e;

   localparam logic [1:0]      CmdStart = 2'b00;
   localparam logic [1:0]      CmdStop  = 2'b01;
   localparam logic [1:0]      CmdWrite = 2'b10;
   localparam logic [1:0]      CmdRead  = 2'b11;
   localparam logic [SIZE-1:0] MinTicks = SIZE'(2);

   state_e          state_q, state_d;
   logic [1:0]      cmd_q, cmd_d;
   logic            bit_q, bit_d;
   logic [SIZE-1:0] ticks_q, ticks_d;
   logic            scl_oe_q, scl_oe_d;
   logic            sda_oe_q, sda_oe_d;
   logic            rx_q, rx_d;
   logic            done_q, done_d;
   logic            arb_q, arb_d;
   logic            scl_s1_q, scl_s2_q;
   logic            sda_s1_q, sda_s2_q;

   // Returns {sda_oe, scl_oe} for a command/bit in phase ph (0=A .. 3=D).
   function automatic logic [1:0] phase_lines(input logic [1:0] cmd, input logic b,
                                              input logic [1:0] ph);
      logic a_or_d;
      logic [1:0] lines;
      a_or_d = (ph == 2'd0) || (ph == 2'd3);
      unique case (cmd)
         CmdStart: lines = {ph[1], ph == 2'd3};
         CmdStop:  lines = {ph != 2'd3, ph == 2'd0};
         CmdWrite: lines = {~b, a_or_d};
         default:  lines = {1'b0, a_or_d};
      endcase
      return lines;
   endfunction

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      bit_d    = bit_q;
      ticks_d  = ticks_q;
      scl_oe_d = scl_oe_q;
      sda_oe_d = sda_oe_q;
      rx_d     = rx_q;
      done_d   = 1'b0;
      arb_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            ticks_d = Ticks_cfg;
            if (Cmd_valid) begin
               cmd_d                = Cmd;
               bit_d                = Tx_bit;
               {sda_oe_d, scl_oe_d} = phase_lines(Cmd, Tx_bit, 2'd0);
               state_d              = StPhA;
            end
         end
         StPhA: begin
            if (Tmr_Out) begin
               if (cmd_q == CmdStart && !sda_s2_q) begin
                  {sda_oe_d, scl_oe_d} = 2'b00;
                  done_d               = 1'b1;
                  arb_d                = 1'b1;
                  state_d              = StIdle;
               end else begin
                  {sda_oe_d, scl_oe_d} = phase_lines(cmd_q, bit_q, 2'd1);
                  state_d              = StPhB;
               end
            end
         end
         StPhB: begin
            if (Tmr_Out) begin
`ifdef I2C_BIT_CTRL_STRETCH_EN
               if (!scl_s2_q) begin
                  state_d = StWaitScl;
               end else begin
                  {sda_oe_d, scl_oe_d} = phase_lines(cmd_q, bit_q, 2'd2);
                  state_d              = StPhC;
               end
`else
               {sda_oe_d, scl_oe_d} = phase_lines(cmd_q, bit_q, 2'd2);
               state_d              = StPhC;
`endif
            end
         end
`ifdef I2C_BIT_CTRL_STRETCH_EN
         StWaitScl: begin
            if (scl_s2_q) begin
               {sda_oe_d, scl_oe_d} = phase_lines(cmd_q, bit_q, 2'd2);
               state_d              = StPhC;
            end
         end
`endif
         StPhC: begin
            if (Tmr_Out) begin
               rx_d = sda_s2_q;
               if (cmd_q == CmdWrite && bit_q && !sda_s2_q) begin
                  {sda_oe_d, scl_oe_d} = 2'b00;
                  done_d               = 1'b1;
                  arb_d                = 1'b1;
                  state_d              = StIdle;
               end else begin
                  {sda_oe_d, scl_oe_d} = phase_lines(cmd_q, bit_q, 2'd3);
                  state_d              = StPhD;
               end
            end
         end
         StPhD: begin
            if (Tmr_Out) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= StIdle;
         cmd_q    <= CmdStart;
         bit_q    <= 1'b0;
         ticks_q  <= '0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
         rx_q     <= 1'b0;
         done_q   <= 1'b0;
         arb_q    <= 1'b0;
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         bit_q    <= bit_d;
         ticks_q  <= ticks_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         rx_q     <= rx_d;
         done_q   <= done_d;
         arb_q    <= arb_d;
         scl_s1_q <= Scl_i;
         scl_s2_q <= scl_s1_q;
         sda_s1_q <= Sda_i;
         sda_s2_q <= sda_s1_q;
      end
   end

`ifndef I2C_BIT_CTRL_STRETCH_EN
   // Synced SCL only matters when stretching is enabled.
   logic unused_scl_sync;
   assign unused_scl_sync = scl_s2_q;
`endif

   assign Cmd_ready = (state_q == StIdle);
   assign Busy      = (state_q != StIdle);
   assign Tmr_Start = (state_q == StIdle) || (state_q == StWaitScl);
   assign Tmr_Stop  = 1'b0;
   assign Tmr_Ticks = (ticks_q < MinTicks) ? MinTicks : ticks_q;
   assign Scl_oe    = scl_oe_q;
   assign Sda_oe    = sda_oe_q;
   assign Rx_bit    = rx_q;
   assign Done      = done_q;
   assign Arb_lost  = arb_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Scoreboard bench for i2c_bit_ctrl: random commands against a phase-table model, with a
// behavioural down-counting bit timer and an open-drain bus model.
module tb_i2c_bit_ctrl;
   localparam int unsigned SIZE = 8;

   logic            Clk = 1'b0;
   logic            Rst_n = 1'b0;
   logic [SIZE-1:0] Ticks_cfg = '0;
   logic [1:0]      Cmd = 2'b00;
   logic            Cmd_valid = 1'b0;
   logic            Cmd_ready;
   logic            Tx_bit = 1'b0;
   logic            Done, Rx_bit, Arb_lost, Busy, Scl_oe, Sda_oe;
   logic            Scl_i, Sda_i;
   logic [SIZE-1:0] Tmr_Ticks;
   logic            Tmr_Start, Tmr_Stop, Tmr_Out;

   logic            ext_low = 1'b0;   // another device holding SDA low
   logic            scl_hold = 1'b0;  // a slave stretching SCL
   logic [SIZE-1:0] tcnt;

   typedef struct packed {
      logic        rx;
      logic        arb;
      logic [1:0]  after;
      logic [2:0]  nph;
      logic [7:0]  trace;
      logic [15:0] lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   logic last_rx = 1'b0;

   i2c_bit_ctrl #(.SIZE(SIZE)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Ticks_cfg(Ticks_cfg), .Cmd(Cmd), .Cmd_valid(Cmd_valid),
      .Cmd_ready(Cmd_ready), .Tx_bit(Tx_bit), .Done(Done), .Rx_bit(Rx_bit),
      .Arb_lost(Arb_lost), .Busy(Busy), .Scl_oe(Scl_oe), .Sda_oe(Sda_oe), .Scl_i(Scl_i),
      .Sda_i(Sda_i), .Tmr_Ticks(Tmr_Ticks), .Tmr_Start(Tmr_Start), .Tmr_Stop(Tmr_Stop),
      .Tmr_Out(Tmr_Out)
   );

   always #5 Clk = ~Clk;

   assign Sda_i = !Sda_oe && !ext_low;
   assign Scl_i = !Scl_oe && !scl_hold;

   // Bit timer: held at reload by Tmr_Start, counts down, pulses at zero and reloads.
   always @(posedge Clk) begin
      if (Tmr_Start || tcnt == '0) tcnt <= Tmr_Ticks;
      else                         tcnt <= tcnt - 1'b1;
   end
   assign Tmr_Out = (tcnt == '0) && !Tmr_Start;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   // Line table: bit ph of each mask is the level in phase ph (0=A .. 3=D).
   function automatic logic [1:0] ref_lines(input logic [1:0] cmd, input logic b, input int ph);
      logic [3:0] s, c;
      case (cmd)
         2'b00:   begin s = 4'b1100;  c = 4'b1000; end
         2'b01:   begin s = 4'b0111;  c = 4'b0001; end
         2'b10:   begin s = {4{~b}};  c = 4'b1001; end
         default: begin s = 4'b0000;  c = 4'b1001; end
      endcase
      return {s[ph], c[ph]};
   endfunction

   // Monitor: traces line levels at each phase end and checks against the scoreboard at Done.
   int         cyc = 0;
   int         ntr = 0;
   logic [7:0] got_tr = '0;
   logic       in_cmd = 1'b0;
   always @(negedge Clk) begin
      exp_t e;
      if (!Rst_n) begin
         in_cmd = 1'b0;
      end else begin
         if (in_cmd) begin
            cyc++;
            if (Tmr_Out) begin
               if (ntr < 4) got_tr[2*ntr +: 2] = {Sda_oe, Scl_oe};
               ntr++;
            end
         end
         if (Done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rx_bit", Rx_bit, e.rx);
               chk("arb_lost", Arb_lost, e.arb);
               chk("lines_after", {Sda_oe, Scl_oe}, e.after);
               chk("phase_count", ntr, e.nph);
               chk("phase_trace", got_tr, e.trace);
               if (e.lat != 0) chk("latency", cyc, e.lat);
            end
            done_cnt++;
            in_cmd = 1'b0;
         end else begin
            chk("arb_without_done", Arb_lost, 1'b0);
         end
         if (Cmd_valid && Cmd_ready) begin
            in_cmd = 1'b1;
            cyc    = 0;
            ntr    = 0;
            got_tr = '0;
         end
      end
   end

   task automatic start_cmd(input logic [1:0] cmd, input logic b, input logic ext,
                            input logic [SIZE-1:0] cfg, input bit skip_lat);
      exp_t e;
      int   t;
      logic [1:0] l;
      Ticks_cfg = cfg;
      repeat (2) begin @(posedge Clk); #1; end
      t     = (cfg < 2) ? 2 : int'(cfg);
      e     = '0;
      e.nph = 3'd4;
      if (cmd == 2'b00 && ext)      begin e.nph = 3'd1; e.arb = 1'b1; end
      if (cmd == 2'b10 && b && ext) begin e.nph = 3'd3; e.arb = 1'b1; end
      if (e.nph >= 3) begin
         l       = ref_lines(cmd, b, 2);
         last_rx = !l[1] && !ext;
      end
      e.rx    = last_rx;
      e.after = e.arb ? 2'b00 : ref_lines(cmd, b, 3);
      for (int ph = 0; ph < int'(e.nph); ph++) e.trace[2*ph +: 2] = ref_lines(cmd, b, ph);
      e.lat = skip_lat ? 16'd0 : 16'(int'(e.nph) * (t + 1) + 1);
      exp_q.push_back(e);
      ext_low   = ext;
      Cmd       = cmd;
      Tx_bit    = b;
      Cmd_valid = 1'b1;
      @(posedge Clk); #1;
      Cmd_valid = 1'b0;
      Cmd       = 2'($urandom);
      Tx_bit    = 1'($urandom);
      Ticks_cfg = SIZE'($urandom);
      chk("busy_after_accept", Busy, 1'b1);
      chk("tmr_ticks_latched", Tmr_Ticks, t);
   endtask

   task automatic wait_done(input int start);
      int i;
      for (i = 0; i < 1200; i++) begin
         @(negedge Clk);
         if (done_cnt != start) break;
      end
      if (i == 1200) begin
         chk("done_timeout", 32'd1, 32'd0);
         exp_q.delete();
      end
      @(posedge Clk); #1;
      ext_low = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] cmd, input logic b, input logic ext,
                          input logic [SIZE-1:0] cfg);
      int s;
      s = done_cnt;
      start_cmd(cmd, b, ext, cfg, 1'b0);
      wait_done(s);
   endtask

   initial begin
      #1;
      chk("rst_scl_oe", Scl_oe, 1'b0);
      chk("rst_sda_oe", Sda_oe, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_rx_bit", Rx_bit, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_tmr_start", Tmr_Start, 1'b1);
      chk("rst_tmr_stop", Tmr_Stop, 1'b0);
      chk("rst_cmd_ready", Cmd_ready, 1'b1);
      repeat (3) @(posedge Clk);
      #1 Rst_n = 1'b1;

      Ticks_cfg = 8'd0;
      repeat (2) begin @(posedge Clk); #1; end
      chk("ticks_clamp_0", Tmr_Ticks, 8'd2);
      Ticks_cfg = 8'd1;
      repeat (2) begin @(posedge Clk); #1; end
      chk("ticks_clamp_1", Tmr_Ticks, 8'd2);

      run_cmd(2'b00, 1'b0, 1'b0, 8'd4);  // START, idle bus
      run_cmd(2'b10, 1'b0, 1'b0, 8'd4);  // WRITE 0
      run_cmd(2'b11, 1'b0, 1'b0, 8'd4);  // READ 1
      run_cmd(2'b10, 1'b1, 1'b1, 8'd4);  // WRITE 1, lost arbitration
      run_cmd(2'b11, 1'b0, 1'b1, 8'd0);  // READ 0
      run_cmd(2'b00, 1'b0, 1'b1, 8'd3);  // START, lost arbitration
      run_cmd(2'b01, 1'b0, 1'b0, 8'd2);  // STOP

      for (int i = 0; i < 40; i++)
         run_cmd(2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0,
                 SIZE'($urandom_range(0, 12)));

`ifdef I2C_BIT_CTRL_STRETCH_EN
      begin
         int s;
         s = done_cnt;
         start_cmd(2'b11, 1'b0, 1'b0, 8'd4, 1'b1);
         repeat (6) begin @(posedge Clk); #1; end
         scl_hold = 1'b1;
         repeat (4) begin @(posedge Clk); #1; end
         for (int i = 0; i < 20; i++) begin
            chk("stretch_tmr_start", Tmr_Start, 1'b1);
            @(posedge Clk); #1;
         end
         scl_hold = 1'b0;
         wait_done(s);
      end
`endif

      // Reset in the middle of PH_C of a WRITE: lines released at once, no Done.
      run_cmd(2'b11, 1'b0, 1'b0, 8'd4);
      start_cmd(2'b10, 1'b1, 1'b0, 8'd4, 1'b0);
      repeat (12) begin @(posedge Clk); #1; end
      Rst_n = 1'b0;
      #1;
      exp_q.delete();
      last_rx = 1'b0;
      chk("midrst_scl_oe", Scl_oe, 1'b0);
      chk("midrst_sda_oe", Sda_oe, 1'b0);
      chk("midrst_busy", Busy, 1'b0);
      chk("midrst_tmr_start", Tmr_Start, 1'b1);
      chk("midrst_done", Done, 1'b0);
      chk("midrst_rx_bit", Rx_bit, 1'b0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      @(negedge Clk);
      chk("postrst_done", Done, 1'b0);
      run_cmd(2'b10, 1'b0, 1'b0, 8'd5);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
